// File: rtl/grid_arbiter_pkg.sv
// Shared definitions for the grid RAM arbiter: requester roles, FSM encoding
// and grid address/data widths.
package grid_arbiter_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  localparam int PLACER  = 0;
  localparam int MOVER   = 1;
  localparam int CLEARER = 2;
  localparam int DISPLAY = 3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/grid_arbiter_rr_pick.sv
// Rotating-priority pick: first requester with req high, searching upward
// from last+1 modulo NUM_REQ. Purely combinational.
module rr_pick
  import grid_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_REQ-1:0] next
);

  logic found;

  always_comb begin
    next  = '0;
    found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      int idx;
      idx = (int'(last) + i) % NUM_REQ;
      if (!found && req[idx]) begin
        next[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/grid_arbiter.sv
// Round-robin arbiter granting bursts of single-port grid RAM access.
// Optional macro GRID_ARB_TIMEOUT_EN force-releases a grant after MAX_BURST beats.
module grid_arbiter
  import grid_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [ADDR_W*NUM_REQ-1:0] req_addr,
  input  logic [DATA_W*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic                      timeout,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

  arb_state_e         state, state_nxt;
  logic [NUM_REQ-1:0] grant_nxt, pick, beat_vec;
  logic [IDX_W-1:0]   last, last_nxt, gidx;
  logic               beat, burst_end, timeout_nxt;

  rr_pick #(
    .NUM_REQ(NUM_REQ),
    .IDX_W  (IDX_W)
  ) u_pick (
    .req (req),
    .last(last),
    .next(pick)
  );

  assign beat_vec = grant & req;
  assign beat     = |beat_vec;
  assign rdata    = mem_rdata;

  // RAM port is steered straight from the registered grant; zero outside a beat
  always_comb begin
    gidx      = '0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant[k]) gidx = IDX_W'(k);
      if (beat_vec[k]) begin
        mem_we    = req_we[k];
        mem_addr  = req_addr[k*ADDR_W +: ADDR_W];
        mem_wdata = req_wdata[k*DATA_W +: DATA_W];
      end
    end
  end

`ifdef GRID_ARB_TIMEOUT_EN
  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  logic [CNT_W-1:0] beat_cnt;

  assign burst_end = beat && (beat_cnt == CNT_W'(MAX_BURST - 1));

  // Held at zero while idle, so every new grant starts counting from zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)               beat_cnt <= '0;
    else if (state == IDLE) beat_cnt <= '0;
    else if (beat)          beat_cnt <= beat_cnt + 1'b1;
  end
`else
  assign burst_end = 1'b0;
`endif

  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant;
    last_nxt    = last;
    timeout_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          grant_nxt = pick;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (!beat || burst_end) begin
          grant_nxt   = '0;
          last_nxt    = gidx;
          state_nxt   = IDLE;
          timeout_nxt = beat;
        end
      end
      default: begin
        grant_nxt = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      grant   <= '0;
      last    <= LAST_RST;
      timeout <= 1'b0;
      rvalid  <= '0;
    end else begin
      state   <= state_nxt;
      grant   <= grant_nxt;
      last    <= last_nxt;
      timeout <= timeout_nxt;
      rvalid  <= beat_vec & ~req_we;
    end
  end

endmodule

// File: tb/tb_grid_arbiter.sv
// Randomized scoreboard bench for grid_arbiter; the reference model follows
// the arbitration rules directly. Build with GRID_ARB_TIMEOUT_EN to model timeouts.
module tb_grid_arbiter;

  localparam int N    = 4;
  localparam int MAXB = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N-1:0]   req_we = '0;
  logic [8*N-1:0] req_addr = '0;
  logic [8*N-1:0] req_wdata = '0;
  logic [7:0]     mem_rdata = '0;
  logic [N-1:0]   grant, rvalid;
  logic [7:0]     rdata, mem_addr, mem_wdata;
  logic           timeout, mem_we;

  grid_arbiter #(.NUM_REQ(N), .MAX_BURST(MAXB)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .grant    (grant),
    .rvalid   (rvalid),
    .rdata    (rdata),
    .timeout  (timeout),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {int cyc; int k; logic we; logic [7:0] addr; logic [7:0] wdata;} acc_t;
  typedef struct {int cyc; int k; logic [7:0] data;} rd_t;

  acc_t         acc_q[$];
  rd_t          rd_q[$];
  logic [N-1:0] gnt_q[$];
  int           to_q[$];

  int vectors = 0, miscompares = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  bit no_new = 1'b0;

  // Reference model: granted requester (-1 = none), rotation pointer, beat count
  int           m_g = -1, m_last = N - 1, m_cnt = 0;
  logic [N-1:0] prev_req = '0;
  int           prev_beat = -1;
  bit           active[N];
  int           rem[N];
  logic [N-1:0] force_mask = '0;
  int           force_rem = 0;

  function automatic logic [7:0] rd_at(int c);
    return 8'(c * 37 + 11);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: compares DUT outputs against the queued expectations
  always @(negedge clk) begin
    if (mon_en) begin
      if (gnt_q.size() > 0) check("grant", 32'(grant), 32'(gnt_q.pop_front()));
      if (|(grant & req)) begin
        if (acc_q.size() == 0) check("beat_unexpected", 1, 0);
        else begin
          acc_t e;
          logic [N-1:0] eg;
          e = acc_q.pop_front();
          eg = '0;
          eg[e.k] = 1'b1;
          check("beat_cycle", 32'(cyc), 32'(e.cyc));
          check("beat_grant", 32'(grant), 32'(eg));
          check("mem_we", 32'(mem_we), 32'(e.we));
          check("mem_addr", 32'(mem_addr), 32'(e.addr));
          check("mem_wdata", 32'(mem_wdata), 32'(e.wdata));
        end
      end else begin
        check("idle_bus", {15'd0, mem_we, mem_addr, mem_wdata}, 0);
        if (acc_q.size() > 0 && acc_q[0].cyc <= cyc) begin
          check("beat_missing", 0, 1);
          void'(acc_q.pop_front());
        end
      end
      if (|rvalid) begin
        if (rd_q.size() == 0) check("rvalid_unexpected", 32'(rvalid), 0);
        else begin
          rd_t r;
          logic [N-1:0] ev;
          r = rd_q.pop_front();
          ev = '0;
          ev[r.k] = 1'b1;
          check("rvalid_cycle", 32'(cyc), 32'(r.cyc));
          check("rvalid", 32'(rvalid), 32'(ev));
          check("rdata", 32'(rdata), 32'(r.data));
        end
      end else if (rd_q.size() > 0 && rd_q[0].cyc <= cyc) begin
        check("rvalid_missing", 0, 1);
        void'(rd_q.pop_front());
      end
      if (timeout) begin
        if (to_q.size() == 0) check("timeout_unexpected", 1, 0);
        else check("timeout_cycle", 32'(cyc), 32'(to_q.pop_front()));
      end else if (to_q.size() > 0 && to_q[0] <= cyc) begin
        check("timeout_missing", 0, 1);
        void'(to_q.pop_front());
      end
    end
  end

  task automatic step();
    logic [N-1:0] r, eg;
    bit           done[N];
    int           beat_k;
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < N; k++) done[k] = 1'b0;
    if (prev_beat >= 0) begin
      rem[prev_beat]--;
      if (rem[prev_beat] <= 0) begin
        active[prev_beat] = 1'b0;
        done[prev_beat]   = 1'b1;
      end
    end
    // Advance the model across the edge using last cycle's requests
    if (m_g < 0) begin
      for (int i = 1; i <= N; i++) begin
        int idx;
        idx = (m_last + i) % N;
        if (m_g < 0 && prev_req[idx]) m_g = idx;
      end
      m_cnt = 0;
    end else if (!prev_req[m_g]) begin
      m_last = m_g;
      m_g    = -1;
    end else begin
`ifdef GRID_ARB_TIMEOUT_EN
      if (m_cnt == MAXB - 1) begin
        m_last = m_g;
        m_g    = -1;
        to_q.push_back(cyc);
      end else m_cnt++;
`endif
    end
    for (int k = 0; k < N; k++) begin
      if (force_mask[k]) begin
        active[k] = 1'b1;
        rem[k]    = force_rem;
      end else if (!active[k] && !done[k] && !no_new && $urandom_range(3) == 0) begin
        active[k] = 1'b1;
        rem[k]    = ($urandom_range(15) == 0) ? $urandom_range(40, 20) : $urandom_range(6, 1);
      end
      r[k] = active[k];
      req_we[k] = 1'($urandom_range(1));
      req_addr[8*k +: 8]  = 8'($urandom_range(255));
      req_wdata[8*k +: 8] = 8'($urandom_range(255));
    end
    force_mask = '0;
    req = r;
    mem_rdata = rd_at(cyc);
    eg = '0;
    if (m_g >= 0) eg[m_g] = 1'b1;
    gnt_q.push_back(eg);
    beat_k = (m_g >= 0 && r[m_g]) ? m_g : -1;
    if (beat_k >= 0) begin
      acc_t e;
      e.cyc = cyc; e.k = beat_k; e.we = req_we[beat_k];
      e.addr = req_addr[8*beat_k +: 8]; e.wdata = req_wdata[8*beat_k +: 8];
      acc_q.push_back(e);
      if (!req_we[beat_k]) begin
        rd_t rr;
        rr.cyc = cyc + 1; rr.k = beat_k; rr.data = rd_at(cyc + 1);
        rd_q.push_back(rr);
      end
    end
    prev_req  = r;
    prev_beat = beat_k;
    mon_en    = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    mon_en = 1'b0;
    rst = 1'b0;
    #1;
    check("rst_grant", 32'(grant), 0);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_rvalid", 32'(rvalid), 0);
    check("rst_timeout", 32'(timeout), 0);
    acc_q.delete(); rd_q.delete(); gnt_q.delete(); to_q.delete();
    m_g = -1; m_last = N - 1; m_cnt = 0;
    prev_req = '0; prev_beat = -1;
    for (int k = 0; k < N; k++) begin
      active[k] = 1'b0;
      rem[k] = 0;
    end
    req = '0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      active[k] = 1'b0;
      rem[k] = 0;
    end
    #12;
    check("por_grant", 32'(grant), 0);
    check("por_rvalid", 32'(rvalid), 0);
    check("por_timeout", 32'(timeout), 0);
    check("por_mem_we", 32'(mem_we), 0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if (i == 400) begin
        do_reset();
        force_mask = 4'b0101;
        force_rem = 3;
      end
      if (i == 800) begin
        do_reset();
        force_mask = 4'b1111;
        force_rem = 2;
      end
      step();
    end
    no_new = 1'b1;
    for (int i = 0; i < 260; i++) step();
    @(negedge clk);
    #1;
    check("beats_outstanding", 32'(acc_q.size()), 0);
    check("reads_outstanding", 32'(rd_q.size()), 0);
    check("timeouts_outstanding", 32'(to_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
